load_refill_dispatcher: RTL and testbench

- DCache-side producer of the load-queue refill interface (lq_en / lqIdx_o / lqData).
- Records which load-queue entries wait on which MSHR, and captures the matching word when the MSHR line refills.
- Returns captured words to the load queue, up to REFILL_PORTS per cycle.
- Sits between the DCache miss path (MSHR refill) and the load queue.

---
 rtl/load_refill_dispatcher.sv | 207 ++++++++++++++++++++
 tb/tb_load_refill_dispatcher.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_refill_dispatcher.sv
// load_refill_dispatcher: waiter table between the DCache MSHR refill path and
// the load queue. Each missing load is parked in a waiter entry tagged with
// its MSHR and word offset; when that MSHR's line refills the word is captured
// and the entry is later returned to the load queue, up to REFILL_PORTS per
// cycle, lowest entry index first.
//
// Handshakes: miss_en/miss_ready is a valid/ready pair; a miss is accepted only
// in a cycle where both are high (and flush is low), and miss_en with
// miss_ready low has no effect. refill_en and lq_en are single-cycle valid
// pulses with no backpressure: a refill is consumed in the cycle it is
// presented, and the load queue must take every lq_en pulse.
module load_refill_dispatcher #(
  parameter int LQ_WIDTH     = 5,
  parameter int MSHR_WIDTH   = 2,
  parameter int WAITER_SIZE  = 8,
  parameter int REFILL_PORTS = 2,
  parameter int DATA_BITS    = 32,
  parameter int LINE_WORDS   = 16,
  localparam int OFF_W       = $clog2(LINE_WORDS)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              miss_en,
  input  logic [LQ_WIDTH-1:0]               miss_lq_idx,
  input  logic [MSHR_WIDTH-1:0]             miss_mshr_idx,
  input  logic [OFF_W-1:0]                  miss_offset,
  output logic                              miss_ready,
  input  logic                              refill_en,
  input  logic [MSHR_WIDTH-1:0]             refill_mshr_idx,
  input  logic [LINE_WORDS*DATA_BITS-1:0]   refill_line,
  input  logic                              flush,
  output logic [REFILL_PORTS-1:0]           lq_en,
  output logic [REFILL_PORTS*LQ_WIDTH-1:0]  lqIdx_o,
  output logic [REFILL_PORTS*DATA_BITS-1:0] lqData
);

  localparam int IDX_W = (WAITER_SIZE > 1) ? $clog2(WAITER_SIZE) : 1;

  // Waiter table
  logic [WAITER_SIZE-1:0] valid_q, valid_d;
  logic [WAITER_SIZE-1:0] ready_q, ready_d;
  logic [LQ_WIDTH-1:0]    lq_idx_q [WAITER_SIZE];
  logic [LQ_WIDTH-1:0]    lq_idx_d [WAITER_SIZE];
  logic [MSHR_WIDTH-1:0]  mshr_q   [WAITER_SIZE];
  logic [MSHR_WIDTH-1:0]  mshr_d   [WAITER_SIZE];
  logic [OFF_W-1:0]       off_q    [WAITER_SIZE];
  logic [OFF_W-1:0]       off_d    [WAITER_SIZE];
  logic [DATA_BITS-1:0]   data_q   [WAITER_SIZE];
  logic [DATA_BITS-1:0]   data_d   [WAITER_SIZE];

  // Registered load-queue write ports
  logic [REFILL_PORTS-1:0] lq_en_q, lq_en_d;
  logic [LQ_WIDTH-1:0]     out_idx_q  [REFILL_PORTS];
  logic [LQ_WIDTH-1:0]     out_idx_d  [REFILL_PORTS];
  logic [DATA_BITS-1:0]    out_data_q [REFILL_PORTS];
  logic [DATA_BITS-1:0]    out_data_d [REFILL_PORTS];

  logic [DATA_BITS-1:0]    line_word [LINE_WORDS];
  logic                    alloc_found;
  logic [IDX_W-1:0]        alloc_idx;
  logic                    alloc_en;
  logic                    bypass;
  logic [WAITER_SIZE-1:0]  match;
  logic [WAITER_SIZE-1:0]  avail;
  logic [WAITER_SIZE-1:0]  pick;
  logic [REFILL_PORTS-1:0] sel_vld;
  logic [IDX_W-1:0]        sel_idx [REFILL_PORTS];

  // Split the refill line into addressable words
  always_comb begin
    for (int k = 0; k < LINE_WORDS; k++) begin
      line_word[k] = refill_line[k*DATA_BITS +: DATA_BITS];
    end
  end

  // Lowest-index free entry for allocation; entries dispatched this cycle
  // are still valid here, so they are never reused in the same cycle
  always_comb begin
    alloc_found = 1'b0;
    alloc_idx   = '0;
    for (int i = 0; i < WAITER_SIZE; i++) begin
      if (!valid_q[i] && !alloc_found) begin
        alloc_found = 1'b1;
        alloc_idx   = IDX_W'(i);
      end
    end
  end

  assign miss_ready = |(~valid_q);
  assign alloc_en   = miss_en && miss_ready && !flush;
  // A miss on the MSHR refilling in the same cycle takes its word directly
  assign bypass     = refill_en && (refill_mshr_idx == miss_mshr_idx);

  // Refill match: only waiting (valid, not yet ready) entries of that MSHR
  always_comb begin
    for (int i = 0; i < WAITER_SIZE; i++) begin
      match[i] = refill_en && !flush && valid_q[i] && !ready_q[i] &&
                 (mshr_q[i] == refill_mshr_idx);
    end
  end

  // Dispatch selection: lowest-index ready entries, port 0 first
  always_comb begin
    avail   = valid_q & ready_q;
    pick    = '0;
    sel_vld = '0;
    for (int p = 0; p < REFILL_PORTS; p++) begin
      sel_idx[p] = '0;
      for (int i = 0; i < WAITER_SIZE; i++) begin
        if (avail[i] && !sel_vld[p]) begin
          sel_vld[p] = 1'b1;
          sel_idx[p] = IDX_W'(i);
          avail[i]   = 1'b0;
          pick[i]    = 1'b1;
        end
      end
    end
  end

  // Table next state: flush wipes everything, else capture, release, allocate
  always_comb begin
    valid_d  = valid_q;
    ready_d  = ready_q;
    lq_idx_d = lq_idx_q;
    mshr_d   = mshr_q;
    off_d    = off_q;
    data_d   = data_q;
    if (flush) begin
      valid_d = '0;
      ready_d = '0;
    end else begin
      for (int i = 0; i < WAITER_SIZE; i++) begin
        if (match[i]) begin
          ready_d[i] = 1'b1;
          data_d[i]  = line_word[off_q[i]];
        end
        if (pick[i]) begin
          valid_d[i] = 1'b0;
          ready_d[i] = 1'b0;
        end
      end
      if (alloc_en) begin
        valid_d[alloc_idx]  = 1'b1;
        ready_d[alloc_idx]  = bypass;
        lq_idx_d[alloc_idx] = miss_lq_idx;
        mshr_d[alloc_idx]   = miss_mshr_idx;
        off_d[alloc_idx]    = miss_offset;
        if (bypass) begin
          data_d[alloc_idx] = line_word[miss_offset];
        end
      end
    end
  end

  // Output port next state; unused ports keep stale idx/data
  always_comb begin
    lq_en_d    = flush ? '0 : sel_vld;
    out_idx_d  = out_idx_q;
    out_data_d = out_data_q;
    for (int p = 0; p < REFILL_PORTS; p++) begin
      if (sel_vld[p]) begin
        out_idx_d[p]  = lq_idx_q[sel_idx[p]];
        out_data_d[p] = data_q[sel_idx[p]];
      end
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
      ready_q <= '0;
      lq_en_q <= '0;
      for (int i = 0; i < WAITER_SIZE; i++) begin
        lq_idx_q[i] <= '0;
        mshr_q[i]   <= '0;
        off_q[i]    <= '0;
        data_q[i]   <= '0;
      end
      for (int p = 0; p < REFILL_PORTS; p++) begin
        out_idx_q[p]  <= '0;
        out_data_q[p] <= '0;
      end
    end else begin
      valid_q    <= valid_d;
      ready_q    <= ready_d;
      lq_idx_q   <= lq_idx_d;
      mshr_q     <= mshr_d;
      off_q      <= off_d;
      data_q     <= data_d;
      lq_en_q    <= lq_en_d;
      out_idx_q  <= out_idx_d;
      out_data_q <= out_data_d;
    end
  end

  // Flatten the per-port registers onto the output buses
  always_comb begin
    for (int p = 0; p < REFILL_PORTS; p++) begin
      lqIdx_o[p*LQ_WIDTH +: LQ_WIDTH]   = out_idx_q[p];
      lqData[p*DATA_BITS +: DATA_BITS] = out_data_q[p];
    end
  end

  assign lq_en = lq_en_q;

endmodule

// File: tb/tb_load_refill_dispatcher.sv
// Self-checking bench for load_refill_dispatcher: directed scenarios push
// expected load-queue writes (port, cycle, lq index, data) into a queue and a
// negedge monitor pops and compares each write the DUT emits.
module tb_load_refill_dispatcher;

  localparam int LQW = 5;
  localparam int MW  = 2;
  localparam int DW  = 32;
  localparam int LW  = 16;
  localparam int OW  = 4;
  localparam int RP  = 2;
  localparam int EW  = 1 + 16 + LQW + DW;

  logic              clk = 1'b0;
  logic              rst;
  logic              miss_en;
  logic [LQW-1:0]    miss_lq_idx;
  logic [MW-1:0]     miss_mshr_idx;
  logic [OW-1:0]     miss_offset;
  logic              miss_ready;
  logic              refill_en;
  logic [MW-1:0]     refill_mshr_idx;
  logic [LW*DW-1:0]  refill_line;
  logic              flush;
  logic [RP-1:0]     lq_en;
  logic [RP*LQW-1:0] lqIdx_o;
  logic [RP*DW-1:0]  lqData;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  load_refill_dispatcher dut (
    .clk             (clk),
    .rst             (rst),
    .miss_en         (miss_en),
    .miss_lq_idx     (miss_lq_idx),
    .miss_mshr_idx   (miss_mshr_idx),
    .miss_offset     (miss_offset),
    .miss_ready      (miss_ready),
    .refill_en       (refill_en),
    .refill_mshr_idx (refill_mshr_idx),
    .refill_line     (refill_line),
    .flush           (flush),
    .lq_en           (lq_en),
    .lqIdx_o         (lqIdx_o),
    .lqData          (lqData)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every write on the load-queue ports must match the
  // next expected entry, including the cycle it was expected in
  always @(negedge clk) begin
    for (int p = 0; p < RP; p++) begin
      if (lq_en[p] === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_lq_en", 64'(lq_en[p]), 64'(0));
        end else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          check("out_port", 64'(p), 64'(e[EW-1]));
          check("out_cycle", 64'(cyc), 64'(e[EW-2 -: 16]));
          check("out_idx", 64'(lqIdx_o[p*LQW +: LQW]), 64'(e[DW +: LQW]));
          check("out_data", 64'(lqData[p*DW +: DW]), 64'(e[DW-1:0]));
        end
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_inputs();
    miss_en         = 1'b0;
    miss_lq_idx     = '0;
    miss_mshr_idx   = '0;
    miss_offset     = '0;
    refill_en       = 1'b0;
    refill_mshr_idx = '0;
    refill_line     = '0;
    flush           = 1'b0;
  endtask

  task automatic drive_miss(input int lq, input int mshr, input int off);
    miss_en       = 1'b1;
    miss_lq_idx   = LQW'(lq);
    miss_mshr_idx = MW'(mshr);
    miss_offset   = OW'(off);
  endtask

  task automatic drive_refill(input int mshr, input logic [LW*DW-1:0] line);
    refill_en       = 1'b1;
    refill_mshr_idx = MW'(mshr);
    refill_line     = line;
  endtask

  task automatic miss(input int lq, input int mshr, input int off);
    drive_miss(lq, mshr, off);
    tick();
    clear_inputs();
  endtask

  task automatic expect_out(input int port, input int dcyc, input int idx, input logic [DW-1:0] data);
    exp_q.push_back({1'(port), 16'(cyc + dcyc), LQW'(idx), data});
  endtask

  function automatic logic [LW*DW-1:0] rand_line();
    logic [LW*DW-1:0] l;
    for (int k = 0; k < LW; k++) l[k*DW +: DW] = $urandom;
    return l;
  endfunction

  function automatic logic [DW-1:0] word_of(input logic [LW*DW-1:0] l, input int k);
    return l[k*DW +: DW];
  endfunction

  logic [LW*DW-1:0] line_a, line_b;
  int offs [8];

  initial begin
    clear_inputs();
    rst = 1'b0;
    idle(3);
    check("rst_lq_en", 64'(lq_en), 64'(0));
    check("rst_lqIdx", 64'(lqIdx_o), 64'(0));
    check("rst_lqData", 64'(lqData), 64'(0));
    rst = 1'b1;
    tick();
    check("rst_miss_ready", 64'(miss_ready), 64'(1));

    // Single miss, refill three cycles later
    miss(3, 1, 5);
    idle(2);
    line_a = rand_line();
    line_a[5*DW +: DW] = 32'hDEADBEEF;
    expect_out(0, 2, 3, 32'hDEADBEEF);
    drive_refill(1, line_a);
    tick();
    clear_inputs();
    idle(5);

    // Three waiters on one MSHR: two ports, then one
    miss(4, 2, 0);
    miss(5, 2, 1);
    miss(6, 2, 2);
    line_a = rand_line();
    line_a[0 +: DW]    = 32'h10;
    line_a[DW +: DW]   = 32'h11;
    line_a[2*DW +: DW] = 32'h12;
    expect_out(0, 2, 4, 32'h10);
    expect_out(1, 2, 5, 32'h11);
    expect_out(0, 3, 6, 32'h12);
    drive_refill(2, line_a);
    tick();
    clear_inputs();
    idle(5);

    // Fill the table; entry 5 waits on MSHR 1, the rest on MSHR 3
    for (int i = 0; i < 8; i++) begin
      offs[i] = $urandom_range(0, LW - 1);
      miss(10 + i, (i == 5) ? 1 : 3, offs[i]);
      check("fill_miss_ready", 64'(miss_ready), 64'(i < 7));
    end
    miss(30, 0, 0);
    check("full_miss_ready", 64'(miss_ready), 64'(0));
    line_a = rand_line();
    expect_out(0, 2, 15, word_of(line_a, offs[5]));
    drive_refill(1, line_a);
    tick();
    clear_inputs();
    check("mr_after_capture", 64'(miss_ready), 64'(0));
    tick();
    check("mr_after_dispatch", 64'(miss_ready), 64'(1));
    miss(20, 2, 3);
    check("mr_refilled", 64'(miss_ready), 64'(0));
    // MSHR 3 refills first, MSHR 2 (the reused entry 5) one cycle later
    line_a = rand_line();
    line_b = rand_line();
    expect_out(0, 2, 10, word_of(line_a, offs[0]));
    expect_out(1, 2, 11, word_of(line_a, offs[1]));
    expect_out(0, 3, 12, word_of(line_a, offs[2]));
    expect_out(1, 3, 13, word_of(line_a, offs[3]));
    expect_out(0, 4, 14, word_of(line_a, offs[4]));
    expect_out(1, 4, 20, word_of(line_b, 3));
    expect_out(0, 5, 16, word_of(line_a, offs[6]));
    expect_out(1, 5, 17, word_of(line_a, offs[7]));
    drive_refill(3, line_a);
    tick();
    clear_inputs();
    drive_refill(2, line_b);
    tick();
    clear_inputs();
    idle(6);
    check("drained_miss_ready", 64'(miss_ready), 64'(1));

    // Bypass: miss and refill of the same MSHR in one cycle
    line_a = rand_line();
    line_a[7*DW +: DW] = 32'h0000CAFE;
    expect_out(0, 2, 9, 32'h0000CAFE);
    drive_miss(9, 0, 7);
    drive_refill(0, line_a);
    tick();
    clear_inputs();
    idle(3);
    drive_refill(0, rand_line());
    tick();
    clear_inputs();
    idle(4);

    // Flush the cycle before two ready entries would be dispatched
    miss(1, 1, 2);
    miss(2, 1, 9);
    drive_refill(1, rand_line());
    tick();
    clear_inputs();
    flush = 1'b1;
    drive_miss(7, 3, 0);
    tick();
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      check("flush_lq_en", 64'(lq_en), 64'(0));
      tick();
    end
    check("flush_miss_ready", 64'(miss_ready), 64'(1));
    drive_refill(1, rand_line());
    tick();
    clear_inputs();
    drive_refill(3, rand_line());
    tick();
    clear_inputs();
    idle(4);

    // Reset in the middle of draining four ready entries
    for (int i = 0; i < 4; i++) miss(21 + i, 2, 4 + i);
    line_a = rand_line();
    expect_out(0, 2, 21, word_of(line_a, 4));
    expect_out(1, 2, 22, word_of(line_a, 5));
    drive_refill(2, line_a);
    tick();
    clear_inputs();
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("midrst_lq_en", 64'(lq_en), 64'(0));
    check("midrst_lqIdx", 64'(lqIdx_o), 64'(0));
    check("midrst_lqData", 64'(lqData), 64'(0));
    check("midrst_miss_ready", 64'(miss_ready), 64'(1));
    tick();
    drive_refill(2, rand_line());
    tick();
    clear_inputs();
    idle(4);

    check("exp_q_empty", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
